// File: rtl/dm_cache_tag_ctrl.sv
// Direct-mapped tag/valid lookup controller fed by an address-file reader.
// Fetches one word address per request, classifies hit/miss, stalls on a miss and keeps hit-rate counters.
module dm_cache_tag_ctrl #(
  parameter int ADDR_W       = 15,
  parameter int OFFSET_W     = 2,
  parameter int INDEX_W      = 10,
  parameter int MISS_PENALTY = 4,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_finish,
  output logic              hit,
  output logic              miss,
  output logic              stall,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  access_count,
  output logic              done
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int PEN_W = (MISS_PENALTY > 1) ? $clog2(MISS_PENALTY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOOKUP,
    S_MISS_WAIT,
    S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [PEN_W-1:0]   pen_reg, pen_next;
  logic               finish_reg, finish_next;
  logic [ADDR_W-1:0]  cur_addr_reg;
  logic [CNT_W-1:0]   hit_count_reg;
  logic [CNT_W-1:0]   access_count_reg;

  logic               valid_reg [LINES];
  logic [TAG_W-1:0]   tag_mem [LINES];

  logic [TAG_W-1:0]   lk_tag;
  logic [INDEX_W-1:0] lk_index;
  logic               lookup_hit;
  logic               fill_en;
  logic               count_access;
  logic               count_hit;

  assign lk_tag     = rd_addr[ADDR_W-1 -: TAG_W];
  assign lk_index   = rd_addr[OFFSET_W +: INDEX_W];
  assign lookup_hit = valid_reg[lk_index] && (tag_mem[lk_index] == lk_tag);

  // Tags are only meaningful behind a set valid bit, so the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[lk_index] <= lk_tag;
    end
  end

  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_reg[gi] <= 1'b0;
      end else if (fill_en && (lk_index == INDEX_W'(gi))) begin
        valid_reg[gi] <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    pen_next     = pen_reg;
    finish_next  = finish_reg;
    rd_en        = 1'b0;
    hit          = 1'b0;
    miss         = 1'b0;
    stall        = 1'b0;
    done         = 1'b0;
    fill_en      = 1'b0;
    count_access = 1'b0;
    count_hit    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        state_next = S_FETCH;
      end
      S_FETCH: begin
        rd_en      = 1'b1;
        state_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        count_access = 1'b1;
        finish_next  = rd_finish;
        if (lookup_hit) begin
          hit        = 1'b1;
          count_hit  = 1'b1;
          state_next = rd_finish ? S_DONE : S_FETCH;
        end else begin
          miss       = 1'b1;
          fill_en    = 1'b1;
          pen_next   = PEN_W'(MISS_PENALTY - 1);
          state_next = S_MISS_WAIT;
        end
      end
      S_MISS_WAIT: begin
        stall = 1'b1;
        if (pen_reg == '0) begin
          state_next = finish_reg ? S_DONE : S_FETCH;
        end else begin
          pen_next = pen_reg - PEN_W'(1);
        end
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= S_IDLE;
      pen_reg          <= '0;
      finish_reg       <= 1'b0;
      cur_addr_reg     <= '0;
      hit_count_reg    <= '0;
      access_count_reg <= '0;
    end else begin
      state_reg  <= state_next;
      pen_reg    <= pen_next;
      finish_reg <= finish_next;
      if (count_access) begin
        cur_addr_reg <= rd_addr;
      end
      // Counters stick at all-ones rather than wrapping.
      if (count_access && (access_count_reg != {CNT_W{1'b1}})) begin
        access_count_reg <= access_count_reg + CNT_W'(1);
      end
      if (count_hit && (hit_count_reg != {CNT_W{1'b1}})) begin
        hit_count_reg <= hit_count_reg + CNT_W'(1);
      end
    end
  end

  assign cur_addr     = cur_addr_reg;
  assign hit_count    = hit_count_reg;
  assign access_count = access_count_reg;

endmodule

// File: tb/tb_dm_cache_tag_ctrl.sv
// Bench for dm_cache_tag_ctrl: table of address files with hand-computed outcomes,
// plus a reset-during-miss sequence and a counter saturation run on a 2-bit-counter instance.
module tb_dm_cache_tag_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst2 = 1'b0;

  logic        rd_en;
  logic [14:0] rd_addr = '0;
  logic        rd_finish = 1'b0;
  logic        hit, miss, stall, done;
  logic [14:0] cur_addr;
  logic [15:0] hit_count, access_count;

  logic        rd_en2;
  logic [14:0] rd_addr2 = '0;
  logic        rd_finish2 = 1'b0;
  logic        hit2, miss2, stall2, done2;
  logic [14:0] cur_addr2;
  logic [1:0]  hit_count2, access_count2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dm_cache_tag_ctrl dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_finish(rd_finish),
    .hit(hit), .miss(miss), .stall(stall), .cur_addr(cur_addr),
    .hit_count(hit_count), .access_count(access_count), .done(done)
  );

  dm_cache_tag_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_finish(rd_finish2),
    .hit(hit2), .miss(miss2), .stall(stall2), .cur_addr(cur_addr2),
    .hit_count(hit_count2), .access_count(access_count2), .done(done2)
  );

  // Reader model: loads the next file entry on the edge where rd_en is high.
  logic [14:0] file_mem [8];
  int          file_len = 1;
  int          file_base = 0;
  int          rptr = 0;
  logic        fire = 1'b0;

  always @(negedge clk) fire = rd_en;
  always @(posedge clk) begin
    if (fire) begin
      #1;
      if ((rptr - file_base) < 8) rd_addr = file_mem[rptr - file_base];
      else rd_addr = '0;
      rd_finish = ((rptr - file_base) >= (file_len - 1));
      rptr = rptr + 1;
    end
  end

  // Second reader: file of five 0x0000 entries.
  int   rptr2 = 0;
  logic fire2 = 1'b0;
  always @(negedge clk) fire2 = rd_en2;
  always @(posedge clk) begin
    if (fire2) begin
      #1;
      rd_addr2 = 15'h0000;
      rd_finish2 = (rptr2 >= 4);
      rptr2 = rptr2 + 1;
    end
  end

  typedef struct {
    int               len;
    logic [3:0][14:0] a;
    logic [3:0]       hmask;
    int               hits;
    int               acc;
    int               stalls;
    int               cycles;
  } vec_t;

  vec_t vecs [4];

  task automatic set_vec(input int i, input int len, input logic [14:0] a0, input logic [14:0] a1,
                         input logic [14:0] a2, input logic [14:0] a3, input logic [3:0] hmask,
                         input int hits, input int acc, input int stalls, input int cycles);
    vecs[i].len = len;
    vecs[i].a[0] = a0; vecs[i].a[1] = a1; vecs[i].a[2] = a2; vecs[i].a[3] = a3;
    vecs[i].hmask = hmask;
    vecs[i].hits = hits;
    vecs[i].acc = acc;
    vecs[i].stalls = stalls;
    vecs[i].cycles = cycles;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  task automatic run_dut(input int max_cycles, output int cycles, output logic [3:0] seq,
                         output int nlook, output int stalls, output int fetches,
                         output int bad, output logic seen_done);
    cycles = 0; seq = '0; nlook = 0; stalls = 0; fetches = 0; bad = 0; seen_done = 1'b0;
    while (cycles < max_cycles && !seen_done) begin
      @(negedge clk);
      cycles++;
      if (hit && miss) bad++;
      if (stall && (hit || miss)) bad++;
      if (hit || miss) begin
        if (nlook < 4) seq[nlook] = hit;
        nlook++;
      end
      if (stall) stalls++;
      if (rd_en) fetches++;
      seen_done = done;
    end
  endtask

  task automatic load_file(input int len, input logic [3:0][14:0] a);
    for (int k = 0; k < 4; k++) file_mem[k] = a[k];
    file_len = len;
    file_base = rptr;
  endtask

  int         cyc, nlook, nstall, nfetch, nbad;
  logic [3:0] seq;
  logic       sdone;

  initial begin
    set_vec(0, 1, 15'h0000, 15'h0000, 15'h0000, 15'h0000, 4'b0000, 0, 1, 4, 7);
    set_vec(1, 3, 15'h0000, 15'h0001, 15'h0003, 15'h0000, 4'b0110, 2, 3, 4, 11);
    set_vec(2, 3, 15'h0000, 15'h1000, 15'h0000, 15'h0000, 4'b0000, 0, 3, 12, 19);
    set_vec(3, 4, 15'h0004, 15'h0008, 15'h0004, 15'h0008, 4'b1100, 2, 4, 8, 17);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst = 1'b0;
      load_file(vecs[i].len, vecs[i].a);
      repeat (2) @(negedge clk);
      check($sformatf("v%0d rst hit_count", i), 32'(hit_count), 32'd0);
      check($sformatf("v%0d rst access_count", i), 32'(access_count), 32'd0);
      check($sformatf("v%0d rst done/rd_en/stall", i), {29'd0, done, rd_en, stall}, 32'd0);
      check($sformatf("v%0d rst cur_addr", i), 32'(cur_addr), 32'd0);
      rst = 1'b1;
      run_dut(60, cyc, seq, nlook, nstall, nfetch, nbad, sdone);
      check($sformatf("v%0d done reached", i), 32'(sdone), 32'd1);
      check($sformatf("v%0d cycles to done", i), 32'(cyc), 32'(vecs[i].cycles));
      check($sformatf("v%0d hit/miss sequence", i), 32'(seq), 32'(vecs[i].hmask));
      check($sformatf("v%0d lookups", i), 32'(nlook), 32'(vecs[i].acc));
      check($sformatf("v%0d fetches", i), 32'(nfetch), 32'(vecs[i].len));
      check($sformatf("v%0d stall cycles", i), 32'(nstall), 32'(vecs[i].stalls));
      check($sformatf("v%0d pulse exclusivity", i), 32'(nbad), 32'd0);
      check($sformatf("v%0d hit_count", i), 32'(hit_count), 32'(vecs[i].hits));
      check($sformatf("v%0d access_count", i), 32'(access_count), 32'(vecs[i].acc));
      check($sformatf("v%0d cur_addr", i), 32'(cur_addr), 32'(vecs[i].a[vecs[i].len-1]));
      if (i == 2) check("v2 tag_mem[0]", 32'(dut.tag_mem[0]), 32'd0);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d done sticky", i), {30'd0, done, rd_en}, 32'd2);
      check($sformatf("v%0d access frozen", i), 32'(access_count), 32'(vecs[i].acc));
    end

    // Reset during the second access's miss penalty; reader keeps its position.
    @(negedge clk);
    rst = 1'b0;
    load_file(3, {15'h0000, 15'h0000, 15'h0004, 15'h0000});
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    while (cyc < 40 && !(stall && access_count == 16'd2)) begin
      @(negedge clk);
      cyc++;
    end
    check("midmiss reached stall", 32'(stall && access_count == 16'd2), 32'd1);
    rst = 1'b0;
    #1;
    check("midmiss async clear", {29'd0, stall, rd_en, done}, 32'd0);
    check("midmiss access_count", 32'(access_count), 32'd0);
    check("midmiss valid[1] cleared", 32'(dut.valid_reg[1]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_dut(60, cyc, seq, nlook, nstall, nfetch, nbad, sdone);
    check("restart done", 32'(sdone), 32'd1);
    check("restart cycles", 32'(cyc), 32'd7);
    check("restart is miss", {28'd0, seq}, 32'd0);
    check("restart lookups", 32'(nlook), 32'd1);
    check("restart access_count", 32'(access_count), 32'd1);
    check("restart hit_count", 32'(hit_count), 32'd0);

    // Saturation with 2-bit counters: miss then four hits.
    @(negedge clk);
    rst2 = 1'b1;
    cyc = 0;
    while (cyc < 100 && !done2) begin
      @(negedge clk);
      cyc++;
      if (hit2 && miss2) check("sat pulse exclusivity", 32'd1, 32'd0);
    end
    check("sat done", 32'(done2), 32'd1);
    check("sat cycles", 32'(cyc), 32'd15);
    check("sat access_count", 32'(access_count2), 32'd3);
    check("sat hit_count", 32'(hit_count2), 32'd3);
    check("sat cur_addr", 32'(cur_addr2 | {14'd0, stall2}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
